// File: rtl/arb_req_pkg.sv
// Shared request-index types and sizing for the arbiter and its downstream queue.
package arb_req_pkg;
  localparam int IDX_W         = 6;
  localparam int ARB_REQ_DEPTH = 4;

  typedef logic [IDX_W-1:0] idx_t;
endpackage

// File: rtl/arb_req_match.sv
// DEPTH-way equality compare of an incoming index against the valid entries of the queue.
module arb_req_match #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 6
) (
  input  logic [IDX_W-1:0]            idx,
  input  logic [DEPTH-1:0][IDX_W-1:0] entries,
  input  logic [DEPTH-1:0]            valid_mask,
  output logic                        hit
);

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_mask[i] && (entries[i] == idx)) hit = 1'b1;
    end
  end

endmodule

// File: rtl/arb_req_queue.sv
// Four-entry in-order request buffer behind the priority arbiter; backpressures it via io_enq_ready.
// Optional ARB_REQ_QUEUE_MERGE_EN: accept-but-drop an enq whose index is already queued.
module arb_req_queue
  import arb_req_pkg::*;
#(
  parameter int DEPTH = ARB_REQ_DEPTH,
  parameter int IDX_W = arb_req_pkg::IDX_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       io_enq_valid,
  input  logic [IDX_W-1:0]           io_enq_bits_req_0_idx,
  output logic                       io_enq_ready,
  output logic                       io_deq_valid,
  output logic [IDX_W-1:0]           io_deq_bits_req_0_idx,
  input  logic                       io_deq_ready,
  output logic [$clog2(DEPTH):0]     io_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0][IDX_W-1:0] mem;
  logic [PTR_W-1:0]            enq_ptr;
  logic [PTR_W-1:0]            deq_ptr;
  logic                        maybe_full;

  logic ptr_match, empty, full;
  logic do_enq, do_deq, do_write;

  assign ptr_match = (enq_ptr == deq_ptr);
  assign empty     = ptr_match & ~maybe_full;
  assign full      = ptr_match & maybe_full;

  // Handshake: a transfer happens on a rising edge where valid & ready are both high.
  // Ready and valid are pure functions of registered state, so neither side has a comb loop.
  assign io_enq_ready          = ~full;
  assign io_deq_valid          = ~empty;
  assign io_deq_bits_req_0_idx = mem[deq_ptr];
  assign io_count              = full ? CNT_W'(DEPTH) : {1'b0, enq_ptr - deq_ptr};

  assign do_enq = io_enq_valid & io_enq_ready;
  assign do_deq = io_deq_valid & io_deq_ready;

`ifdef ARB_REQ_QUEUE_MERGE_EN
  logic [DEPTH-1:0] valid_mask;
  logic             merge_hit;

  // An entry is live if it sits within the occupied window; the head leaving this cycle is not.
  always_comb begin
    logic [PTR_W-1:0] off;
    valid_mask = '0;
    off        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PTR_W'(i) - deq_ptr;
      valid_mask[i] = full | (CNT_W'(off) < io_count);
      if (do_deq && (PTR_W'(i) == deq_ptr)) valid_mask[i] = 1'b0;
    end
  end

  arb_req_match #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_match (
    .idx        (io_enq_bits_req_0_idx),
    .entries    (mem),
    .valid_mask (valid_mask),
    .hit        (merge_hit)
  );

  assign do_write = do_enq & ~merge_hit;
`else
  assign do_write = do_enq;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      enq_ptr    <= '0;
      deq_ptr    <= '0;
      maybe_full <= 1'b0;
    end else begin
      if (do_write) enq_ptr <= enq_ptr + PTR_W'(1);
      if (do_deq)   deq_ptr <= deq_ptr + PTR_W'(1);
      if (do_write != do_deq) maybe_full <= do_write;
    end
  end

  // Storage is deliberately not reset; gating on reset keeps a dropped enq out of the array.
  always_ff @(posedge clock) begin
    if (!reset && do_write) mem[enq_ptr] <= io_enq_bits_req_0_idx;
  end

endmodule

// File: tb/tb_arb_req_queue.sv
// Self-checking bench for arb_req_queue against a queue-based reference of the buffer.
module tb_arb_req_queue;

  localparam int DEPTH = 4;
  localparam int IDX_W = 6;

  logic             clock;
  logic             reset;
  logic             io_enq_valid;
  logic [IDX_W-1:0] io_enq_bits_req_0_idx;
  logic             io_enq_ready;
  logic             io_deq_valid;
  logic [IDX_W-1:0] io_deq_bits_req_0_idx;
  logic             io_deq_ready;
  logic [2:0]       io_count;

  logic [IDX_W-1:0] exp_q[$];
  logic [IDX_W-1:0] deq_log[$];
  logic [IDX_W-1:0] want_seq[$];
  int n_cmp;
  int n_err;

  arb_req_queue #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .io_enq_valid          (io_enq_valid),
    .io_enq_bits_req_0_idx (io_enq_bits_req_0_idx),
    .io_enq_ready          (io_enq_ready),
    .io_deq_valid          (io_deq_valid),
    .io_deq_bits_req_0_idx (io_deq_bits_req_0_idx),
    .io_deq_ready          (io_deq_ready),
    .io_count              (io_count)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One cycle: drive at negedge, check outputs against the model, then advance the model.
  task automatic step(input logic ev, input logic [IDX_W-1:0] ei, input logic dr, input string tag);
    logic fire_enq, fire_deq, hit;
    @(negedge clock);
    io_enq_valid = ev;
    io_enq_bits_req_0_idx = ei;
    io_deq_ready = dr;
    #1;
    n_cmp++;
    if (io_count !== 3'(exp_q.size())) begin
      n_err++;
      $display("FAIL %s count: got %0d want %0d", tag, io_count, exp_q.size());
    end
    n_cmp++;
    if (io_enq_ready !== (exp_q.size() < DEPTH)) begin
      n_err++;
      $display("FAIL %s enq_ready: got %b want %b", tag, io_enq_ready, exp_q.size() < DEPTH);
    end
    n_cmp++;
    if (io_deq_valid !== (exp_q.size() > 0)) begin
      n_err++;
      $display("FAIL %s deq_valid: got %b want %b", tag, io_deq_valid, exp_q.size() > 0);
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      if (io_deq_bits_req_0_idx !== exp_q[0]) begin
        n_err++;
        $display("FAIL %s deq_bits: got %h want %h", tag, io_deq_bits_req_0_idx, exp_q[0]);
      end
    end
    fire_deq = dr && (exp_q.size() > 0);
    fire_enq = ev && (exp_q.size() < DEPTH);
    if (fire_deq) deq_log.push_back(exp_q.pop_front());
    if (fire_enq) begin
      hit = 1'b0;
`ifdef ARB_REQ_QUEUE_MERGE_EN
      foreach (exp_q[k]) if (exp_q[k] == ei) hit = 1'b1;
`endif
      if (!hit) exp_q.push_back(ei);
    end
    @(posedge clock);
  endtask

  task automatic apply_reset(input logic ev, input logic [IDX_W-1:0] ei);
    @(negedge clock);
    reset = 1'b1;
    io_enq_valid = ev;
    io_enq_bits_req_0_idx = ei;
    io_deq_ready = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    io_enq_valid = 1'b0;
    exp_q.delete();
  endtask

  task automatic drain(input int cycles, input string tag);
    for (int i = 0; i < cycles; i++) step(1'b0, '0, 1'b1, tag);
  endtask

  task automatic check_log(input string tag);
    n_cmp++;
    if (deq_log.size() != want_seq.size()) begin
      n_err++;
      $display("FAIL %s seq_len: got %0d want %0d", tag, deq_log.size(), want_seq.size());
    end else begin
      foreach (want_seq[k]) begin
        n_cmp++;
        if (deq_log[k] !== want_seq[k]) begin
          n_err++;
          $display("FAIL %s seq[%0d]: got %h want %h", tag, k, deq_log[k], want_seq[k]);
        end
      end
    end
  endtask

  task automatic test_reset();
    apply_reset(1'b0, '0);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, "reset_idle");
  endtask

  task automatic test_fill_stall();
    deq_log.delete();
    step(1'b1, 6'h05, 1'b0, "fill");
    step(1'b1, 6'h11, 1'b0, "fill");
    step(1'b1, 6'h2A, 1'b0, "fill");
    step(1'b1, 6'h3F, 1'b0, "fill");
    step(1'b1, 6'h07, 1'b0, "fill_stall");
    step(1'b1, 6'h07, 1'b0, "fill_stall");
    step(1'b1, 6'h07, 1'b1, "fill_release");
    step(1'b1, 6'h07, 1'b1, "fill_release");
    drain(6, "fill_drain");
    want_seq = '{6'h05, 6'h11, 6'h2A, 6'h3F, 6'h07};
    check_log("fill");
  endtask

  task automatic test_stream();
    deq_log.delete();
    want_seq.delete();
    for (int i = 0; i < 12; i++) begin
      step(1'b1, IDX_W'(i), 1'b1, "stream");
      want_seq.push_back(IDX_W'(i));
    end
    drain(2, "stream_drain");
    check_log("stream");
  endtask

  task automatic test_full_simul();
    deq_log.delete();
    for (int i = 0; i < 4; i++) step(1'b1, IDX_W'(6'h20 + i), 1'b0, "full_fill");
    step(1'b1, 6'h33, 1'b1, "full_simul");
    step(1'b1, 6'h33, 1'b0, "full_after");
    drain(6, "full_drain");
    want_seq = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h33};
    check_log("full_simul");
  endtask

  task automatic test_reset_mid();
    deq_log.delete();
    for (int i = 0; i < 3; i++) step(1'b1, IDX_W'(6'h10 + i), 1'b0, "mid_fill");
    apply_reset(1'b1, 6'h2B);
    drain(4, "mid_after");
    n_cmp++;
    if (deq_log.size() != 0) begin
      n_err++;
      $display("FAIL reset_mid deq_count: got %0d want 0", deq_log.size());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, IDX_W'($urandom_range(0, 7)), $urandom_range(0, 2) != 0, "random");
    drain(6, "random_drain");
  endtask

`ifdef ARB_REQ_QUEUE_MERGE_EN
  task automatic test_merge();
    deq_log.delete();
    step(1'b1, 6'h09, 1'b0, "merge");
    step(1'b1, 6'h09, 1'b0, "merge");
    step(1'b1, 6'h14, 1'b0, "merge");
    step(1'b0, '0, 1'b0, "merge_cnt");
    drain(3, "merge_drain");
    want_seq = '{6'h09, 6'h14};
    check_log("merge");
    deq_log.delete();
    step(1'b1, 6'h09, 1'b0, "merge_head");
    step(1'b1, 6'h21, 1'b0, "merge_head");
    step(1'b1, 6'h09, 1'b1, "merge_head_deq");
    step(1'b0, '0, 1'b0, "merge_head_cnt");
    drain(4, "merge_head_drain");
    want_seq = '{6'h09, 6'h21, 6'h09};
    check_log("merge_head");
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    io_enq_valid = 1'b0;
    io_enq_bits_req_0_idx = '0;
    io_deq_ready = 1'b0;
    repeat (3) @(posedge clock);
    test_reset();
    test_fill_stall();
    test_stream();
    test_full_simul();
    test_reset_mid();
    test_random();
`ifdef ARB_REQ_QUEUE_MERGE_EN
    test_merge();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
